// File: rtl/uart_pkg.sv
// Shared UART definitions: default link parameters, receiver FSM states and a
// width helper. uart_transmit uses the same defaults, so both ends of the link
// agree on the baud rate and the frame width.
package uart_pkg;

    // 50 MHz system clock, 115200 baud, 8N1
    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_e;

    // Bits needed to hold values 0..value-1, never less than one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned span = 1; span < value; span = span * 2) begin
            width = width + 1;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/uart_receive_sync2.sv
// Two-flop synchronizer for a single asynchronous input. The reset value is
// a parameter so that idle-high lines (UART RX) and idle-low lines (buttons,
// switches) both come out of reset in their inactive state.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw input through two flops; bit 1 is the settled copy
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {2{RST_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receive.sv
// UART receiver: LSB-first frames with one start and one stop bit, idle
// high. The line is synchronized, each start edge is re-checked half a bit
// later, and data and stop bits are then sampled at their bit centres. A good
// frame updates rx_data and pulses o_valid; a low stop bit pulses o_frame_err
// and waits for the line to go high before looking for another start edge.
module uart_receive
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = UART_DATA_BITS,
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CNT_W = clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;

    // Shift register extended by the incoming bit; dropping bit 0 gives the
    // LSB-first shift and stays legal when DATA_BITS is 1
    logic [DATA_BITS:0]     shift_ext;

    sync2 #(
        .RST_VAL(1'b1)
    ) u_rx_sync (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign shift_ext = {rx_s, shift_q};

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Frame sequencing: start qualification, bit-centre sampling, stop check
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        // Line went back high before mid-bit: treat as noise
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = shift_ext[DATA_BITS:1];
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        // Back to IDLE straight away so a start edge half a
                        // bit later is still caught
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_HIGH: begin
                // A held-low line (break) must not be read as further frames
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data     = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_receive.sv
// Testbench for uart_receive with DATA_BITS=8, CLKS_PER_BIT=16. The serial line
// is driven in picoseconds so that bit periods other than a whole number of
// clocks can be used. Each frame sent adds its outcome to a queue of expected
// events; a monitor records the strobes the receiver produces.
`timescale 1ps/1ps
module tb_uart_receive;

    localparam int unsigned DB     = 8;
    localparam int unsigned CPB    = 16;
    localparam int unsigned CLK_PS = 10000;
    localparam int unsigned BIT_PS = CPB * CLK_PS;
    localparam int unsigned OBS_N  = 512;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          rx    = 1'b1;
    logic [DB-1:0] rx_data;
    logic          o_valid;
    logic          o_frame_err;
    logic          o_busy;

    uart_receive #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .rx          (rx),
        .rx_data     (rx_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #(CLK_PS / 2) i_clk = ~i_clk;

    int unsigned cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Observed strobes, written only by the monitor
    bit          obs_ferr [OBS_N];
    logic [7:0]  obs_data [OBS_N];
    int unsigned obs_cyc  [OBS_N];
    int unsigned obs_n     = 0;
    int unsigned overlap_n = 0;
    int unsigned busy_n    = 0;

    always @(negedge i_clk) begin
        if (o_valid || o_frame_err) begin
            if (obs_n < OBS_N) begin
                obs_ferr[obs_n] <= o_frame_err;
                obs_data[obs_n] <= rx_data;
                obs_cyc[obs_n]  <= cyc;
            end
            obs_n <= obs_n + 1;
        end
        if (o_valid && o_frame_err) overlap_n <= overlap_n + 1;
        if (o_busy) busy_n <= busy_n + 1;
    end

    // Reference model: one expected outcome per frame, plus the last good word
    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  model_data = 8'h00;
    int unsigned obs_rd     = 0;
    int unsigned n_checks   = 0;
    int unsigned n_pass     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive one complete frame; the line is left at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int unsigned bit_ps);
        rx = 1'b0;
        #(bit_ps);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_ps);
        end
        rx = stop_ok;
        #(bit_ps);
        if (stop_ok) begin
            exp_q.push_back('{ferr: 1'b0, data: d});
            model_data = d;
        end else begin
            exp_q.push_back('{ferr: 1'b1, data: 8'h00});
        end
    endtask

    task automatic idle_bits(input int unsigned n);
        rx = 1'b1;
        #(n * BIT_PS);
    endtask

    // Compare everything observed since the last call with the model queue
    task automatic check_events(input string tag);
        ev_t e;
        check({tag, " count"}, obs_n - obs_rd, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_n) begin
                check({tag, " kind"}, obs_ferr[obs_rd], e.ferr);
                if (!e.ferr) check({tag, " data"}, obs_data[obs_rd], e.data);
                obs_rd++;
            end
        end
        obs_rd = obs_n;
        check({tag, " rx_data held"}, rx_data, model_data);
    endtask

    initial begin
        int unsigned k, i0, b0, bp;
        logic [7:0]  d;
        bit          ok;
        logic [7:0]  loop_bytes [4];

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("reset rx_data", rx_data, 8'h00);
        check("reset valid", o_valid, 1'b0);
        check("reset ferr", o_frame_err, 1'b0);
        check("reset busy", o_busy, 1'b0);
        i_rst = 1'b0;
        idle_bits(1);

        // Ideal 0xA5 with strobe latency measured from the line edge
        @(posedge i_clk);
        #1;
        k  = cyc;
        i0 = obs_n;
        send_frame(8'hA5, 1'b1, BIT_PS);
        idle_bits(2);
        check("a5 latency", obs_cyc[i0], k + 2 + 1 + 7 + 16 * 9 + 1);
        check_events("a5");

        // Back-to-back frames with no idle between stop and next start
        loop_bytes = '{8'h00, 8'hFF, 8'h55, 8'h80};
        for (int i = 0; i < 4; i++) send_frame(loop_bytes[i], 1'b1, BIT_PS);
        idle_bits(2);
        check_events("loopback");

        // 5-cycle low glitch on an idle line
        b0 = busy_n;
        @(posedge i_clk);
        #1;
        rx = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        rx = 1'b1;
        idle_bits(3);
        check("glitch busy seen", busy_n > b0, 1'b1);
        check("glitch busy idle", o_busy, 1'b0);
        check_events("glitch");
        send_frame(8'h3C, 1'b1, BIT_PS);
        idle_bits(2);
        check_events("after glitch");

        // Low stop bit followed by a 40-bit break
        send_frame(8'h12, 1'b0, BIT_PS);
        #(40 * BIT_PS);
        check("break busy", o_busy, 1'b1);
        check_events("break");
        idle_bits(2);
        send_frame(8'h34, 1'b1, BIT_PS);
        idle_bits(2);
        check_events("after break");

        // Reset pulse during data bit 4 of 0x77
        d = 8'h77;
        @(posedge i_clk);
        #1;
        rx = 1'b0;
        #(BIT_PS);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            #(BIT_PS);
        end
        rx = d[4];
        #(BIT_PS / 2);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("abort rx_data", rx_data, 8'h00);
        check("abort busy", o_busy, 1'b0);
        check("abort valid", o_valid, 1'b0);
        model_data = 8'h00;
        idle_bits(3);
        check_events("abort");
        send_frame(8'h99, 1'b1, BIT_PS);
        idle_bits(2);
        check_events("after abort");

        // +/-4% baud skew
        send_frame(8'hC3, 1'b1, BIT_PS * 96 / 100);
        idle_bits(2);
        check_events("fast baud");
        send_frame(8'hC3, 1'b1, BIT_PS * 104 / 100);
        idle_bits(2);
        check_events("slow baud");

        // Random words, skew within +/-3%, random gaps, occasional bad stop
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom);
            bp = BIT_PS - 4800 + $urandom_range(0, 9600);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(d, ok, bp);
            if (!ok) begin
                #($urandom_range(1, 4) * BIT_PS);
                idle_bits(2);
            end else begin
                idle_bits($urandom_range(0, 2));
            end
        end
        idle_bits(2);
        check_events("random");

        check("valid/ferr overlap", overlap_n, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
